// File: rtl/qa_shim_buffer_afu_nch.sv
// Per-channel request FIFOs between an AFU and its Tx interface, with optional same-cycle bypass.
// Define QA_SHIM_BUFFER_ERR_CHECK_EN to build the sticky overflow/underflow detectors.
module qa_shim_buffer_afu_nch #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 61,
  parameter int N_ENTRIES = 6,
  parameter int THRESHOLD = 4,
  parameter logic [N_CHANNELS-1:0] BYPASS_MASK = '0,
  localparam int CW = $clog2(N_ENTRIES + 1)
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic [N_CHANNELS-1:0]            raw_valid,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] raw_data,
  output logic [N_CHANNELS-1:0]            raw_almFull,
  output logic [N_CHANNELS-1:0]            buf_valid,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] buf_data,
  input  logic [N_CHANNELS-1:0]            deq,
  output logic [N_CHANNELS*CW-1:0]         occupancy,
  output logic [N_CHANNELS-1:0]            err_overflow,
  output logic [N_CHANNELS-1:0]            err_underflow
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam logic [CW-1:0] DEPTH = CW'(N_ENTRIES);
  localparam logic [CW-1:0] ALM_LEVEL = CW'(N_ENTRIES - THRESHOLD);
  localparam logic [PW-1:0] LAST_SLOT = PW'(N_ENTRIES - 1);

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]         count_reg, count_next;
    logic                  alm_reg;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  fifo_empty, fifo_full, head_from_raw;
    logic                  head_valid, pop, enq;

    assign in_data    = raw_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH);

    if (BYPASS_MASK[gi]) begin : g_bypass
      assign head_from_raw = fifo_empty;
    end else begin : g_no_bypass
      assign head_from_raw = 1'b0;
    end

    // A bypassed request taken in the same cycle never touches the FIFO.
    always_comb begin
      head_valid = head_from_raw ? raw_valid[gi] : !fifo_empty;
      pop        = deq[gi] && head_valid && !head_from_raw;
      enq        = raw_valid[gi] && !(head_from_raw && deq[gi]) && (!fifo_full || pop);
      count_next = count_reg;
      if (enq && !pop)
        count_next = count_reg + 1'b1;
      else if (pop && !enq)
        count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        alm_reg    <= 1'b1;
      end else begin
        if (enq)
          wr_ptr_reg <= (wr_ptr_reg == LAST_SLOT) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= (rd_ptr_reg == LAST_SLOT) ? '0 : rd_ptr_reg + 1'b1;
        count_reg <= count_next;
        alm_reg   <= (count_next >= ALM_LEVEL);
      end
    end

    // Storage has no reset: contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
      if (enq)
        mem[wr_ptr_reg] <= in_data;
    end

    assign buf_valid[gi]                           = head_valid;
    assign buf_data[gi*DATA_WIDTH +: DATA_WIDTH]   = head_from_raw ? in_data : mem[rd_ptr_reg];
    assign occupancy[gi*CW +: CW]                  = count_reg;
    assign raw_almFull[gi]                         = alm_reg;

`ifdef QA_SHIM_BUFFER_ERR_CHECK_EN
    logic ovf_reg, unf_reg;

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end else begin
        if (raw_valid[gi] && fifo_full && !pop)
          ovf_reg <= 1'b1;
        if (deq[gi] && !head_valid)
          unf_reg <= 1'b1;
      end
    end

    assign err_overflow[gi]  = ovf_reg;
    assign err_underflow[gi] = unf_reg;
`else
    assign err_overflow[gi]  = 1'b0;
    assign err_underflow[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_qa_shim_buffer_afu_nch.sv
// Directed/random bench: default config, bypass config and a 5-deep config, checked against queues.
module tb_qa_shim_buffer_afu_nch;

`ifdef QA_SHIM_BUFFER_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Instance A: defaults
  logic [1:0]   a_valid = '0, a_deq = '0, a_alm, a_bv, a_ovf, a_unf;
  logic [121:0] a_data = '0, a_bd;
  logic [5:0]   a_occ;
  // Instance B: channel 0 bypass, channel 1 plain
  logic [1:0]   b_valid = '0, b_deq = '0, b_alm, b_bv, b_ovf, b_unf;
  logic [15:0]  b_data = '0, b_bd;
  logic [5:0]   b_occ;
  // Instance C: non-power-of-two depth
  logic [0:0]   c_valid = '0, c_deq = '0, c_alm, c_bv, c_ovf, c_unf;
  logic [7:0]   c_data = '0, c_bd;
  logic [2:0]   c_occ;

  qa_shim_buffer_afu_nch dut_a (
    .clk(clk), .resetb(resetb), .raw_valid(a_valid), .raw_data(a_data),
    .raw_almFull(a_alm), .buf_valid(a_bv), .buf_data(a_bd), .deq(a_deq),
    .occupancy(a_occ), .err_overflow(a_ovf), .err_underflow(a_unf)
  );

  qa_shim_buffer_afu_nch #(.N_CHANNELS(2), .DATA_WIDTH(8), .BYPASS_MASK(2'b01)) dut_b (
    .clk(clk), .resetb(resetb), .raw_valid(b_valid), .raw_data(b_data),
    .raw_almFull(b_alm), .buf_valid(b_bv), .buf_data(b_bd), .deq(b_deq),
    .occupancy(b_occ), .err_overflow(b_ovf), .err_underflow(b_unf)
  );

  qa_shim_buffer_afu_nch #(.N_CHANNELS(1), .DATA_WIDTH(8), .N_ENTRIES(5), .THRESHOLD(2)) dut_c (
    .clk(clk), .resetb(resetb), .raw_valid(c_valid), .raw_data(c_data),
    .raw_almFull(c_alm), .buf_valid(c_bv), .buf_data(c_bd), .deq(c_deq),
    .occupancy(c_occ), .err_overflow(c_ovf), .err_underflow(c_unf)
  );

  logic [60:0] qa0[$];
  logic [60:0] qa1[$];
  logic [7:0]  qc[$];
  logic [1:0]  exp_ovf = '0;
  logic [1:0]  exp_unf = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One cycle on instance A, channel ch. Called and returns at a falling edge.
  task automatic a_step(input int ch, input bit en, input logic [60:0] val, input bit dq);
    int occ;
    bit popped;
    logic [60:0] e;
    occ = (ch == 0) ? qa0.size() : qa1.size();
    a_valid = '0;
    a_deq = '0;
    a_data = '0;
    a_valid[ch] = en;
    a_deq[ch] = dq;
    a_data[ch*61 +: 61] = val;
    #1;
    popped = dq && (occ > 0);
    if (popped) begin
      if (ch == 0) e = qa0.pop_front();
      else e = qa1.pop_front();
      check($sformatf("a_head%0d", ch), 64'(a_bd[ch*61 +: 61]), 64'(e));
    end
    if (dq && occ == 0) exp_unf[ch] = ERR_ON;
    if (en) begin
      if (occ < 6 || popped) begin
        if (ch == 0) qa0.push_back(val);
        else qa1.push_back(val);
      end else begin
        exp_ovf[ch] = ERR_ON;
      end
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = '0;
    a_deq = '0;
    occ = (ch == 0) ? qa0.size() : qa1.size();
    $display("A ch%0d en=%0b val=%0h deq=%0b -> occ=%0d", ch, en, val, dq, a_occ[ch*3 +: 3]);
    check($sformatf("a_occ%0d", ch), 64'(a_occ[ch*3 +: 3]), 64'(occ));
    check($sformatf("a_bv%0d", ch), 64'(a_bv[ch]), 64'(occ != 0));
    check($sformatf("a_alm%0d", ch), 64'(a_alm[ch]), 64'((6 - occ) <= 4));
  endtask

  task automatic c_step(input bit en, input logic [7:0] val, input bit dq);
    int occ;
    bit popped;
    logic [7:0] e;
    occ = qc.size();
    c_valid[0] = en;
    c_deq[0] = dq;
    c_data = val;
    #1;
    popped = dq && (occ > 0);
    if (popped) begin
      e = qc.pop_front();
      check("c_head", 64'(c_bd), 64'(e));
    end
    if (en && (occ < 5 || popped)) qc.push_back(val);
    @(posedge clk);
    @(negedge clk);
    c_valid = '0;
    c_deq = '0;
    $display("C en=%0b val=%0h deq=%0b -> occ=%0d", en, val, dq, c_occ);
    check("c_occ", 64'(c_occ), 64'(qc.size()));
    check("c_bv", 64'(c_bv), 64'(qc.size() != 0));
    check("c_alm", 64'(c_alm), 64'((5 - qc.size()) <= 2));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check("rst_a_occ", 64'(a_occ), 64'd0);
    check("rst_a_bv", 64'(a_bv), 64'd0);
    check("rst_a_alm", 64'(a_alm), 64'h3);
    check("rst_a_err", 64'({a_ovf, a_unf}), 64'd0);
    check("rst_c_alm", 64'(c_alm), 64'h1);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("rel_a_alm", 64'(a_alm), 64'h0);
    check("rel_b_alm", 64'(b_alm), 64'h0);
    check("rel_c_alm", 64'(c_alm), 64'h0);

    // Fill ch0 with 1..6, then full enq+deq, then drain
    for (int i = 1; i <= 6; i++) a_step(0, 1'b1, 61'(i), 1'b0);
    a_step(0, 1'b1, 61'h55, 1'b1);
    for (int i = 0; i < 6; i++) a_step(0, 1'b0, 61'h0, 1'b1);
    // Enq+deq at occupancy 1, wide payload
    a_step(0, 1'b1, 61'h1ABC_DEF0_1234_5678, 1'b0);
    a_step(0, 1'b1, 61'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    a_step(0, 1'b0, 61'h0, 1'b1);
    a_step(0, 1'b0, 61'h0, 1'b1);

    // Overflow on ch1, then drain past empty
    for (int i = 1; i <= 6; i++) a_step(1, 1'b1, 61'(32'h1000 + i), 1'b0);
    a_step(1, 1'b1, 61'h1FFF, 1'b0);
    for (int i = 0; i < 7; i++) a_step(1, 1'b0, 61'h0, 1'b1);
    check("a_err_ovf", 64'(a_ovf), 64'(exp_ovf));
    check("a_err_unf", 64'(a_unf), 64'(exp_unf));

    // Bypass: ch0 taken same cycle, ch1 buffered
    b_valid = 2'b11;
    b_data = 16'hCDAB;
    b_deq = 2'b01;
    #1;
    $display("B bypass take 0xAB, ch1 enq 0xCD");
    check("b_bv0_same", 64'(b_bv[0]), 64'h1);
    check("b_bd0_same", 64'(b_bd[7:0]), 64'hAB);
    check("b_bv1_same", 64'(b_bv[1]), 64'h0);
    @(posedge clk);
    @(negedge clk);
    b_valid = '0;
    b_deq = '0;
    check("b_occ0", 64'(b_occ[2:0]), 64'd0);
    check("b_occ1", 64'(b_occ[5:3]), 64'd1);
    check("b_bd1", 64'(b_bd[15:8]), 64'hCD);
    b_valid = 2'b01;
    b_data = 16'h0011;
    #1;
    $display("B bypass present 0x11 without deq");
    check("b_bd0_pass", 64'(b_bd[7:0]), 64'h11);
    @(posedge clk);
    @(negedge clk);
    b_data = 16'h0022;
    b_deq = 2'b01;
    #1;
    $display("B non-empty: head 0x11, enq 0x22, deq");
    check("b_head_fifo", 64'(b_bd[7:0]), 64'h11);
    @(posedge clk);
    @(negedge clk);
    b_valid = '0;
    b_deq = '0;
    check("b_occ0_after", 64'(b_occ[2:0]), 64'd1);
    check("b_head_next", 64'(b_bd[7:0]), 64'h22);

    // Depth 5: random interleave, reset pulse mid-stream
    for (int i = 0; i < 20; i++)
      c_step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    #2;
    resetb = 1'b0;
    #1;
    $display("C reset pulse");
    check("c_rst_occ", 64'(c_occ), 64'd0);
    check("c_rst_bv", 64'(c_bv), 64'd0);
    check("c_rst_alm", 64'(c_alm), 64'h1);
    qc.delete();
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("c_rel_alm", 64'(c_alm), 64'h0);
    for (int i = 0; i < 10; i++)
      c_step(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qa_shim_buffer_afu_nch.md
QA_SHIM_BUFFER_AFU_NCH -- requirements
Module: qa_shim_buffer_afu_nch

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 2: number of independent Tx request channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 61: payload bits per channel, carried opaque (header or header+data).
REQ-003 SHALL have parameter N_ENTRIES, default 6: FIFO depth per channel; legal range 2..64.
REQ-004 SHALL have parameter THRESHOLD, default 4: almost-full asserts when free slots <= THRESHOLD; legal range 1..N_ENTRIES-1.
REQ-005 SHALL have parameter BYPASS_MASK, default 0: N_CHANNELS-bit mask; bit i set enables same-cycle bypass on channel i.
REQ-006 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-007 SHALL have port resetb, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port raw_valid, input, N_CHANNELS: AFU-side request valid, one per channel.
REQ-009 SHALL have port raw_data, input, N_CHANNELS*DATA_WIDTH: AFU-side payload, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port raw_almFull, output, N_CHANNELS: per-channel back-pressure to AFU.
REQ-011 SHALL have port buf_valid, output, N_CHANNELS: buffered head valid.
REQ-012 SHALL have port buf_data, output, N_CHANNELS*DATA_WIDTH: buffered head payload, same packing as raw_data.
REQ-013 SHALL have port deq, input, N_CHANNELS: consumer removes head of channel i.
REQ-014 SHALL have port occupancy, output, N_CHANNELS*CW, CW=$clog2(N_ENTRIES+1): entries held per channel.
REQ-015 SHALL have port err_overflow, output, N_CHANNELS: sticky enq-while-full flag.
REQ-016 SHALL have port err_underflow, output, N_CHANNELS: sticky deq-while-nothing-valid flag.

Function
REQ-017 Channels SHALL be fully independent; no cross-channel ordering or arbitration.
REQ-018 Non-bypass channel: raw_valid at cycle t SHALL enqueue; buf_valid/buf_data visible at t+1; buf_valid = occupancy != 0.
REQ-019 FIFO order SHALL be strict first-in first-out; buf_data SHALL hold the head until deq.
REQ-020 deq with buf_valid low SHALL be ignored (no state change).
REQ-021 Simultaneous enq and deq SHALL leave occupancy unchanged, including when full and when occupancy is 1.
REQ-022 enq while occupancy == N_ENTRIES without same-cycle deq SHALL drop the request, occupancy unchanged.
REQ-023 raw_almFull[i] SHALL equal (N_ENTRIES - occupancy[i]) <= THRESHOLD, derived from registered occupancy only (no combinational path from raw_valid or deq).
REQ-024 Bypass channel, FIFO empty: buf_valid = raw_valid and buf_data = raw_data in the same cycle; if deq same cycle, request SHALL NOT be enqueued.
REQ-025 Bypass channel, FIFO non-empty: FIFO head SHALL be presented; new raw request enqueued; ordering preserved.
REQ-026 Read and write pointers SHALL wrap modulo N_ENTRIES; non-power-of-two depths SHALL work.

Reset
REQ-027 resetb low SHALL asynchronously empty all FIFOs: occupancy 0, buf_valid 0, err flags 0.
REQ-028 raw_almFull SHALL read all-ones while resetb is low and all-zeros the first cycle after release.
REQ-029 Reset mid-operation SHALL discard buffered requests; buf_data is don't-care while buf_valid is 0.

Configuration
REQ-030 Macro QA_SHIM_BUFFER_ERR_CHECK_EN defined: err_overflow[i] SHALL set on any REQ-022 drop and err_underflow[i] on any REQ-020 ignored deq; both sticky until reset.
REQ-031 Macro undefined: err_overflow and err_underflow SHALL be constant 0 and the detection logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Defaults, 6 enqueues ch0 (values 1..6), no deq -> raw_almFull[0] rises after the 2nd enqueue registers (occupancy 2), occupancy 6; deq x6 returns 1..6 in order.
REQ-033 Full ch1, 7th enq with no deq -> dropped, occupancy stays 6, err_overflow[1]=1 (macro on) / 0 (macro off).
REQ-034 Full ch0, enq 0x55 with deq same cycle -> occupancy 6, 0x55 emerges after remaining 5 entries.
REQ-035 BYPASS_MASK=1, empty ch0, raw_valid with 0xAB and deq same cycle -> buf_valid=1, buf_data=0xAB that cycle, occupancy stays 0.
REQ-036 N_ENTRIES=5, THRESHOLD=2, 20 enq/deq interleaved random -> scoreboard order match across pointer wrap; resetb pulse mid-stream -> occupancy 0, buf_valid 0 immediately.
